csr_sys_ctrl: RTL and testbench

- Sequences SYSTEM-class instructions for the multicycle core against the machine-mode CSR file: CSRRW/CSRRS/CSRRC, ECALL, EBREAK and MRET.
- Performs the CSR read-modify-write, raises trap entry or MRET toward the CSR file, and returns rd data and a PC redirect to the core FSM.
- Sits between the core control unit and the CSR register file; it is the only driver of the CSR file's we/addr/wdata/trap_entry/mret inputs.

---
 rtl/csr_sys_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_csr_sys_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_sys_ctrl.sv
// Sequences SYSTEM-class instructions (CSRRW/RS/RC, ECALL, EBREAK, MRET) against the M-mode CSR file.
// Latency from accept to resp_valid: 3 cycles for CSR ops, 2 cycles for trap/MRET.
// Backpressure: req_ready only in IDLE; responses carry none and must be consumed in their cycle.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_*                     request from the core control unit (valid/ready handshake)
//   csr_addr/we/wdata/rdata   read-modify-write access to the CSR file
//   trap_entry/pc/cause, mret trap and return strobes toward the CSR file
//   mtvec_in, mepc_in         redirect targets read from the CSR file
//   resp_*                    one-cycle completion pulse with rd writeback and PC redirect
module csr_sys_ctrl #(
  parameter logic [3:0] MCAUSE_ILLEGAL = 4'd2,
  parameter logic [3:0] MCAUSE_BREAK   = 4'd3,
  parameter logic [3:0] MCAUSE_ECALL_M = 4'd11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_src,
  input  logic        req_src_x0,
  input  logic [31:0] req_pc,
  output logic [11:0] csr_addr,
  output logic        csr_we,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        trap_entry,
  output logic [31:0] trap_pc,
  output logic [3:0]  trap_cause,
  output logic        mret,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        resp_valid,
  output logic        resp_rd_we,
  output logic [31:0] resp_rd_data,
  output logic        resp_redirect,
  output logic [31:0] resp_pc
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_TRAP  = 3'd3,
    S_RET   = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam logic [2:0] OP_RW   = 3'd0;
  localparam logic [2:0] OP_RS   = 3'd1;
  localparam logic [2:0] OP_RC   = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_BREAK = 3'd4;
  localparam logic [2:0] OP_MRET  = 3'd5;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] src_q, src_d;
  logic        src_x0_q, src_x0_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  cause_q, cause_d;
  logic [31:0] old_q, old_d;

  logic        resp_is_csr;
  logic        resp_is_mret;

  function automatic logic csr_impl(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h305) || (a == 12'h341) || (a == 12'h342);
  endfunction

  // The RESP flavour is re-derived from the latched request instead of
  // carrying a separate kind register: a CSR op that reached RESP must have
  // had an implemented address, everything else except MRET was a trap.
  assign resp_is_csr  = (op_q <= OP_RC) && csr_impl(addr_q);
  assign resp_is_mret = (op_q == OP_MRET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      src_q    <= '0;
      src_x0_q <= 1'b0;
      pc_q     <= '0;
      cause_q  <= '0;
      old_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      src_q    <= src_d;
      src_x0_q <= src_x0_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      old_q    <= old_d;
    end
  end

  // All strobes are pure decodes of state_q so an asynchronous reset
  // removes them in the same cycle.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    src_d         = src_q;
    src_x0_d      = src_x0_q;
    pc_d          = pc_q;
    cause_d       = cause_q;
    old_d         = old_q;

    req_ready     = 1'b0;
    csr_addr      = '0;
    csr_we        = 1'b0;
    csr_wdata     = '0;
    trap_entry    = 1'b0;
    trap_pc       = '0;
    trap_cause    = '0;
    mret          = 1'b0;
    resp_valid    = 1'b0;
    resp_rd_we    = 1'b0;
    resp_rd_data  = '0;
    resp_redirect = 1'b0;
    resp_pc       = '0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d     = req_op;
          addr_d   = req_addr;
          src_d    = req_src;
          src_x0_d = req_src_x0;
          pc_d     = req_pc;
          cause_d  = '0;
          case (req_op)
            OP_RW, OP_RS, OP_RC: begin
              if (csr_impl(req_addr)) begin
                state_d = S_READ;
              end else begin
                state_d = S_TRAP;
                cause_d = MCAUSE_ILLEGAL;
              end
            end
            OP_ECALL: begin
              state_d = S_TRAP;
              cause_d = MCAUSE_ECALL_M;
            end
            OP_BREAK: begin
              state_d = S_TRAP;
              cause_d = MCAUSE_BREAK;
            end
            OP_MRET: begin
              state_d = S_RET;
            end
            default: begin
              state_d = S_TRAP;
              cause_d = MCAUSE_ILLEGAL;
            end
          endcase
        end
      end

      S_READ: begin
        csr_addr = addr_q;
        old_d    = csr_rdata;
        state_d  = S_WRITE;
      end

      S_WRITE: begin
        csr_addr = addr_q;
        case (op_q)
          OP_RW:   csr_wdata = src_q;
          OP_RS:   csr_wdata = old_q | src_q;
          OP_RC:   csr_wdata = old_q & ~src_q;
          default: csr_wdata = '0;
        endcase
        // Set/clear with an x0/zimm-0 source must not write (side-effect free
        // read); a plain swap always writes.
        csr_we  = (op_q == OP_RW) || !src_x0_q;
        state_d = S_RESP;
      end

      S_TRAP: begin
        trap_entry = 1'b1;
        trap_pc    = pc_q;
        trap_cause = cause_q;
        state_d    = S_RESP;
      end

      S_RET: begin
        mret    = 1'b1;
        state_d = S_RESP;
      end

      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_is_csr) begin
          resp_rd_we   = 1'b1;
          resp_rd_data = old_q;
        end else if (resp_is_mret) begin
          resp_redirect = 1'b1;
          resp_pc       = mepc_in;
        end else begin
          // mtvec_in is sampled here, so a preceding mtvec write is seen.
          resp_redirect = 1'b1;
          resp_pc       = mtvec_in;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_sys_ctrl.sv
module tb_csr_sys_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_src;
  logic        req_src_x0;
  logic [31:0] req_pc;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        trap_entry;
  logic [31:0] trap_pc;
  logic [3:0]  trap_cause;
  logic        mret;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic        resp_valid;
  logic        resp_rd_we;
  logic [31:0] resp_rd_data;
  logic        resp_redirect;
  logic [31:0] resp_pc;

  csr_sys_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_src(req_src), .req_src_x0(req_src_x0), .req_pc(req_pc),
    .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .trap_entry(trap_entry), .trap_pc(trap_pc), .trap_cause(trap_cause), .mret(mret),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .resp_valid(resp_valid), .resp_rd_we(resp_rd_we), .resp_rd_data(resp_rd_data),
    .resp_redirect(resp_redirect), .resp_pc(resp_pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Minimal CSR file environment: mstatus, mtvec, mepc, mcause.
  logic        env_init = 1'b0;
  logic [31:0] m_status, m_tvec, m_epc, m_cause;
  always @(posedge clk) begin
    if (env_init) begin
      m_status <= 32'h0000_1800;
      m_tvec   <= 32'h8000_0004;
      m_epc    <= 32'h0000_1234;
      m_cause  <= 32'h0000_000B;
    end else if (csr_we) begin
      case (csr_addr)
        12'h300: m_status <= csr_wdata;
        12'h305: m_tvec   <= csr_wdata;
        12'h341: m_epc    <= csr_wdata;
        12'h342: m_cause  <= csr_wdata;
        default: ;
      endcase
    end
  end
  assign csr_rdata = (csr_addr == 12'h300) ? m_status :
                     (csr_addr == 12'h305) ? m_tvec   :
                     (csr_addr == 12'h341) ? m_epc    :
                     (csr_addr == 12'h342) ? m_cause  : 32'h0;
  assign mtvec_in = m_tvec;
  assign mepc_in  = m_epc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kind: 0 CSR op, 1 trap, 2 MRET
  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] src;
    logic        x0;
    logic [31:0] pc;
    logic [1:0]  kind;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  cause;
    logic [31:0] rd_data;
    logic [31:0] rpc;
  } vec_t;

  typedef struct {
    logic        rd_we;
    logic [31:0] rd_data;
    logic        redirect;
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  function automatic vec_t mk(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                              input logic x0, input logic [31:0] pc, input logic [1:0] kind,
                              input logic we, input logic [31:0] wdata, input logic [3:0] cause,
                              input logic [31:0] rd_data, input logic [31:0] rpc);
    vec_t v;
    v.op = op; v.addr = addr; v.src = src; v.x0 = x0; v.pc = pc; v.kind = kind;
    v.we = we; v.wdata = wdata; v.cause = cause; v.rd_data = rd_data; v.rpc = rpc;
    return v;
  endfunction

  // Response monitor: pops the scoreboard when the DUT completes.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_rd_we", {31'b0, resp_rd_we}, {31'b0, e.rd_we});
        chk("resp_redirect", {31'b0, resp_redirect}, {31'b0, e.redirect});
        if (e.rd_we)    chk("resp_rd_data", resp_rd_data, e.rd_data);
        if (e.redirect) chk("resp_pc", resp_pc, e.pc);
      end
    end
  end

  // Drives one request in the IDLE cycle and checks the strobes of every
  // following cycle up to and including RESP; returns in the RESP cycle so
  // the next call issues back-to-back.
  task automatic run_row(input vec_t v);
    exp_t e;
    int   lat;
    int   acc;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_op     = v.op;
    req_addr   = v.addr;
    req_src    = v.src;
    req_src_x0 = v.x0;
    req_pc     = v.pc;
    lat        = (v.kind == 2'd0) ? 3 : 2;
    acc        = cyc;
    e.rd_we    = (v.kind == 2'd0);
    e.rd_data  = v.rd_data;
    e.redirect = (v.kind != 2'd0);
    e.pc       = v.rpc;
    e.cyc      = acc + lat;
    sb.push_back(e);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
      chk("csr_addr", {20'b0, csr_addr}, (v.kind == 2'd0 && k <= 2) ? {20'b0, v.addr} : 32'd0);
      chk("csr_we", {31'b0, csr_we}, {31'b0, (v.kind == 2'd0 && k == 2 && v.we)});
      if (v.kind == 2'd0 && k == 2 && v.we) chk("csr_wdata", csr_wdata, v.wdata);
      chk("trap_entry", {31'b0, trap_entry}, {31'b0, (v.kind == 2'd1 && k == 1)});
      chk("trap_pc", trap_pc, (v.kind == 2'd1 && k == 1) ? v.pc : 32'd0);
      chk("trap_cause", {28'b0, trap_cause}, (v.kind == 2'd1 && k == 1) ? {28'b0, v.cause} : 32'd0);
      chk("mret", {31'b0, mret}, {31'b0, (v.kind == 2'd2 && k == 1)});
    end
  endtask

  vec_t tbl[13];
  vec_t tail[2];

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_src = '0; req_src_x0 = 1'b0; req_pc = '0;

    tbl[0]  = mk(3'd0, 12'h305, 32'h100, 1'b0, 32'h0,  2'd0, 1'b1, 32'h100,  4'd0,  32'h8000_0004, 32'h0);
    tbl[1]  = mk(3'd1, 12'h300, 32'h8,   1'b1, 32'h0,  2'd0, 1'b0, 32'h0,    4'd0,  32'h1800,      32'h0);
    tbl[2]  = mk(3'd1, 12'h300, 32'h8,   1'b0, 32'h0,  2'd0, 1'b1, 32'h1808, 4'd0,  32'h1800,      32'h0);
    tbl[3]  = mk(3'd2, 12'h342, 32'hF,   1'b0, 32'h0,  2'd0, 1'b1, 32'h0,    4'd0,  32'hB,         32'h0);
    tbl[4]  = mk(3'd3, 12'h000, 32'h0,   1'b0, 32'h40, 2'd1, 1'b0, 32'h0,    4'd11, 32'h0,         32'h100);
    tbl[5]  = mk(3'd4, 12'h000, 32'h0,   1'b0, 32'h44, 2'd1, 1'b0, 32'h0,    4'd3,  32'h0,         32'h100);
    tbl[6]  = mk(3'd0, 12'h344, 32'h55,  1'b0, 32'h48, 2'd1, 1'b0, 32'h0,    4'd2,  32'h0,         32'h100);
    tbl[7]  = mk(3'd7, 12'h300, 32'h0,   1'b0, 32'h4C, 2'd1, 1'b0, 32'h0,    4'd2,  32'h0,         32'h100);
    tbl[8]  = mk(3'd5, 12'h000, 32'h0,   1'b0, 32'h50, 2'd2, 1'b0, 32'h0,    4'd0,  32'h0,         32'h1234);
    tbl[9]  = mk(3'd2, 12'h341, 32'h4,   1'b0, 32'h0,  2'd0, 1'b1, 32'h1230, 4'd0,  32'h1234,      32'h0);
    tbl[10] = mk(3'd0, 12'h305, 32'h200, 1'b1, 32'h0,  2'd0, 1'b1, 32'h200,  4'd0,  32'h100,       32'h0);
    tbl[11] = mk(3'd3, 12'h000, 32'h0,   1'b0, 32'h54, 2'd1, 1'b0, 32'h0,    4'd11, 32'h0,         32'h200);
    tbl[12] = mk(3'd6, 12'h305, 32'h0,   1'b0, 32'h58, 2'd1, 1'b0, 32'h0,    4'd2,  32'h0,         32'h200);
    tail[0] = mk(3'd1, 12'h300, 32'h0,   1'b1, 32'h0,  2'd0, 1'b0, 32'h0,    4'd0,  32'h1808,      32'h0);
    tail[1] = mk(3'd4, 12'h000, 32'h0,   1'b0, 32'h60, 2'd1, 1'b0, 32'h0,    4'd3,  32'h0,         32'h200);

    env_init = 1'b1;
    repeat (2) @(negedge clk);
    env_init = 1'b0;

    // Reset values
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_csr_we", {31'b0, csr_we}, 32'd0);
    chk("rst_trap_entry", {31'b0, trap_entry}, 32'd0);
    chk("rst_mret", {31'b0, mret}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_csr_addr", {20'b0, csr_addr}, 32'd0);
    chk("rst_csr_wdata", csr_wdata, 32'd0);
    chk("rst_resp_pc", resp_pc, 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) run_row(tbl[i]);

    // Reset in the WRITE cycle: strobe must vanish before the edge.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_addr = 12'h341; req_src = 32'hDEAD_BEEF; req_src_x0 = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("wr_before_rst_we", {31'b0, csr_we}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_csr_we", {31'b0, csr_we}, 32'd0);
    chk("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_mepc_kept", m_epc, 32'h1230);

    foreach (tail[i]) run_row(tail[i]);
    @(negedge clk);
    @(negedge clk);

    chk("pending_resp", sb.size(), 32'd0);
    chk("final_mstatus", m_status, 32'h1808);
    chk("final_mtvec", m_tvec, 32'h200);
    chk("final_mepc", m_epc, 32'h1230);
    chk("final_mcause", m_cause, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
